// File: rtl/ntt_pkg.sv
// Shared parameters, types and Barrett constant helpers for the NTT datapath.
package ntt_pkg;

    localparam int unsigned NTT_DATA_W = 32;
    localparam int unsigned NTT_Q      = 12289;

    typedef logic [NTT_DATA_W-1:0] coeff_t;

    typedef enum logic {
        BF_CT = 1'b0,
        BF_GS = 1'b1
    } bfly_mode_e;

    // K = ceil(log2 q)
    function automatic int unsigned ntt_k(input int unsigned q);
        int unsigned k;
        k = 0;
        while ((64'd1 << k) < 64'(q)) begin
            k = k + 1;
        end
        return k;
    endfunction

    // MU = floor(2^(2K) / q)
    function automatic int unsigned ntt_mu(input int unsigned q);
        longint unsigned num;
        num = 64'd1 << (2 * ntt_k(q));
        return 32'(num / 64'(q));
    endfunction

endpackage

// File: rtl/barrett_reduce.sv
// Two-stage Barrett reduction of a double-width product into [0,Q).
module barrett_reduce
    import ntt_pkg::*;
#(
    parameter int unsigned DATA_W = NTT_DATA_W,
    parameter int unsigned Q      = NTT_Q
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [2*DATA_W-1:0] m,
    output logic [DATA_W-1:0]   red
);

    localparam int unsigned K    = ntt_k(Q);
    localparam int unsigned MU   = ntt_mu(Q);
    localparam int unsigned MW   = 2 * DATA_W;
    localparam int unsigned RW   = DATA_W + 1;
    localparam logic [MW-1:0] Q_M  = MW'(Q);
    localparam logic [MW-1:0] MU_M = MW'(MU);
    localparam logic [RW-1:0] Q_R  = RW'(Q);

    logic [MW-1:0] est_c;
    logic [MW-1:0] qh_c;
    logic [RW-1:0] r_q;
    logic [RW-1:0] r1_c;
    logic [RW-1:0] r2_c;

    // Quotient estimate leaves r below 3Q, so two conditional subtracts finish it
    always_comb begin
        est_c = (m >> (K - 1)) * MU_M;
        qh_c  = est_c >> (K + 1);
        r1_c  = (r_q >= Q_R) ? r_q - Q_R : r_q;
        r2_c  = (r1_c >= Q_R) ? r1_c - Q_R : r1_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            red <= '0;
        end else if (en) begin
            r_q <= RW'(m - qh_c * Q_M);
            red <= DATA_W'(r2_c);
        end
    end

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined CT/GS modular butterfly, fixed 4-cycle latency, whole-pipe stall.
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int unsigned DATA_W = NTT_DATA_W,
    parameter int unsigned Q      = NTT_Q
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1
);

    localparam int unsigned MW = 2 * DATA_W;
    localparam int unsigned SW = DATA_W + 1;
    localparam logic [SW-1:0] Q_S = SW'(Q);

    logic              en;
    logic              s1_v, s2_v, s3_v, s4_v;
    bfly_mode_e        s1_mode, s2_mode, s3_mode, s4_mode;
    logic [DATA_W-1:0] s1_x0, s1_x1, s1_w;
    logic [DATA_W-1:0] s2_x0, s3_x0, s4_x0;
    logic [MW-1:0]     s2_m;
    logic [DATA_W-1:0] red;

    logic [SW-1:0]     pre_sum_c, pre_dif_c, post_sum_c, post_dif_c;
    logic [DATA_W-1:0] x0_c, x1_c, y0_c, y1_c;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // GS pre-add/subtract; CT passes operands straight through
    always_comb begin
        pre_sum_c = SW'(a) + SW'(b);
        if (pre_sum_c >= Q_S) begin
            pre_sum_c = pre_sum_c - Q_S;
        end
        pre_dif_c = (a >= b) ? SW'(a) - SW'(b) : SW'(a) + Q_S - SW'(b);
        x0_c      = mode ? DATA_W'(pre_sum_c) : a;
        x1_c      = mode ? DATA_W'(pre_dif_c) : b;
    end

    // CT post-add/subtract of the reduced product; GS result is already final
    always_comb begin
        post_sum_c = SW'(s4_x0) + SW'(red);
        if (post_sum_c >= Q_S) begin
            post_sum_c = post_sum_c - Q_S;
        end
        post_dif_c = (s4_x0 >= red) ? SW'(s4_x0) - SW'(red)
                                    : SW'(s4_x0) + Q_S - SW'(red);
        y0_c = (s4_mode == BF_GS) ? s4_x0 : DATA_W'(post_sum_c);
        y1_c = (s4_mode == BF_GS) ? red   : DATA_W'(post_dif_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s3_v      <= 1'b0;
            s4_v      <= 1'b0;
            out_valid <= 1'b0;
            s1_mode   <= BF_CT;
            s2_mode   <= BF_CT;
            s3_mode   <= BF_CT;
            s4_mode   <= BF_CT;
            s1_x0     <= '0;
            s1_x1     <= '0;
            s1_w      <= '0;
            s2_x0     <= '0;
            s3_x0     <= '0;
            s4_x0     <= '0;
            s2_m      <= '0;
            y0        <= '0;
            y1        <= '0;
        end else if (en) begin
            s1_v      <= in_valid;
            s1_mode   <= bfly_mode_e'(mode);
            s1_x0     <= x0_c;
            s1_x1     <= x1_c;
            s1_w      <= w;
            s2_v      <= s1_v;
            s2_mode   <= s1_mode;
            s2_x0     <= s1_x0;
            s2_m      <= MW'(s1_x1) * MW'(s1_w);
            s3_v      <= s2_v;
            s3_mode   <= s2_mode;
            s3_x0     <= s2_x0;
            s4_v      <= s3_v;
            s4_mode   <= s3_mode;
            s4_x0     <= s3_x0;
            out_valid <= s4_v;
            y0        <= y0_c;
            y1        <= y1_c;
        end
    end

    barrett_reduce #(
        .DATA_W (DATA_W),
        .Q      (Q)
    ) u_barrett (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .m   (s2_m),
        .red (red)
    );

endmodule

// File: tb/tb_ntt_butterfly.sv
// Randomized bench for ntt_butterfly against a plain modular-arithmetic reference.
module tb_ntt_butterfly;

    localparam int unsigned DW = 32;
    localparam int unsigned QM = 12289;

    typedef struct packed {
        logic          mode;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] w;
        logic          has_exp;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } beat_t;

    typedef struct {
        longint unsigned y0;
        longint unsigned y1;
        int              edge_n;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic [DW-1:0] w = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] y0;
    logic [DW-1:0] y1;

    int      n_tests = 0;
    int      n_fail  = 0;
    int      cyc     = 0;
    logic    chk_lat = 1'b0;
    logic    prev_stall = 1'b0;
    logic [DW-1:0] hold_y0 = '0;
    logic [DW-1:0] hold_y1 = '0;
    beat_t   stim_q[$];
    exp_t    exp_q[$];

    always #5 clk = ~clk;

    ntt_butterfly #(
        .DATA_W (DW),
        .Q      (QM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void ref_bfly(input beat_t bt, output longint unsigned r0, output longint unsigned r1);
        longint unsigned q, av, bv, wv, t;
        q  = QM;
        av = bt.a;
        bv = bt.b;
        wv = bt.w;
        if (!bt.mode) begin
            t  = (wv * bv) % q;
            r0 = (av + t) % q;
            r1 = (av + q - t) % q;
        end else begin
            r0 = (av + bv) % q;
            r1 = (((av + q - bv) % q) * wv) % q;
        end
    endfunction

    function automatic logic [DW-1:0] pick_val();
        int unsigned sel;
        sel = $urandom_range(7, 0);
        if (sel == 0) return DW'(QM - 1);
        if (sel == 1) return '0;
        return DW'($urandom_range(QM - 1, 0));
    endfunction

    function automatic beat_t rnd_beat();
        beat_t bt;
        bt         = '0;
        bt.mode    = 1'($urandom_range(1, 0));
        bt.a       = pick_val();
        bt.b       = pick_val();
        bt.w       = pick_val();
        bt.has_exp = 1'b0;
        return bt;
    endfunction

    function automatic beat_t dir_beat(input logic md, input int unsigned av, input int unsigned bv,
                                       input int unsigned wv, input int unsigned r0, input int unsigned r1);
        beat_t bt;
        bt         = '0;
        bt.mode    = md;
        bt.a       = DW'(av);
        bt.b       = DW'(bv);
        bt.w       = DW'(wv);
        bt.has_exp = 1'b1;
        bt.e0      = DW'(r0);
        bt.e1      = DW'(r1);
        return bt;
    endfunction

    // One clock: drive at negedge, sample outputs just after, score at posedge
    task automatic cycle_step(input logic iv, input beat_t bt, input logic ordy,
                              output logic acc, output logic popped);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        mode      = bt.mode;
        a         = bt.a;
        b         = bt.b;
        w         = bt.w;
        out_ready = ordy;
        #1;
        if (exp_q.size() == 0) begin
            check("idle_valid", out_valid, 0);
        end else if (out_valid) begin
            check("y0", y0, exp_q[0].y0);
            check("y1", y1, exp_q[0].y1);
            if (chk_lat) check("latency", longint'(cyc - 1 - exp_q[0].edge_n), 4);
        end
        if (prev_stall) begin
            check("y0_hold", y0, hold_y0);
            check("y1_hold", y1, hold_y1);
        end
        if (out_valid && !ordy) check("in_ready_stall", in_ready, 0);
        prev_stall = out_valid && !ordy;
        hold_y0    = y0;
        hold_y1    = y1;
        acc        = iv && in_ready;
        popped     = out_valid && ordy && (exp_q.size() > 0);
        @(posedge clk);
        if (popped) void'(exp_q.pop_front());
        if (acc) begin
            if (bt.has_exp) begin
                e.y0 = bt.e0;
                e.y1 = bt.e1;
            end else begin
                ref_bfly(bt, e.y0, e.y1);
            end
            e.edge_n = cyc;
            exp_q.push_back(e);
        end
        cyc++;
    endtask

    task automatic run_stream(input int stall_at, input int stall_len, input logic lat);
        int    n_beats;
        int    n_out;
        int    step;
        logic  acc;
        logic  popped;
        logic  iv;
        logic  ordy;
        beat_t bt;
        n_beats = stim_q.size();
        n_out   = 0;
        step    = 0;
        chk_lat = lat;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && step < 1000) begin
            ordy = !(step >= stall_at && step < stall_at + stall_len);
            iv   = stim_q.size() > 0;
            if (iv) bt = stim_q[0];
            else    bt = '0;
            cycle_step(iv, bt, ordy, acc, popped);
            if (acc) void'(stim_q.pop_front());
            if (popped) n_out++;
            step++;
        end
        check("stream_done", longint'(stim_q.size() + exp_q.size()), 0);
        check("beat_count", longint'(n_out), longint'(n_beats));
    endtask

    initial begin
        logic acc;
        logic popped;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y0", y0, 0);
        check("rst_y1", y1, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Directed values, including the all-(Q-1) corner
        stim_q.push_back(dir_beat(1'b0, 5, 10, 2, 25, 12274));
        stim_q.push_back(dir_beat(1'b1, 5, 10, 2, 15, 12279));
        stim_q.push_back(dir_beat(1'b0, 12288, 12288, 12288, 0, 12287));
        stim_q.push_back(dir_beat(1'b1, 12288, 12288, 12288, 12287, 0));
        run_stream(10000, 0, 1'b1);

        // Back-to-back random stream with mixed modes
        for (int i = 0; i < 100; i++) stim_q.push_back(rnd_beat());
        run_stream(10000, 0, 1'b1);

        // Backpressure while results are presented
        for (int i = 0; i < 10; i++) stim_q.push_back(rnd_beat());
        run_stream(7, 3, 1'b0);

        // Reset with three beats in flight
        chk_lat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle_step(1'b1, rnd_beat(), 1'b1, acc, popped);
            check("pre_rst_accept", acc, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_y0", y0, 0);
        check("mid_rst_y1", y1, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle_step(1'b0, '0, 1'b1, acc, popped);
        stim_q.push_back(rnd_beat());
        stim_q.push_back(rnd_beat());
        run_stream(10000, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
